// File: rtl/hop_chain_checker.sv
`timescale 1ns/1ps
// Purpose : traffic source/sink for a hopN chain; launches start pulses, times arrival, counts errors.
// Latency : start is registered (high the cycle after run is seen in IDLE); results update one cycle after arrival.
// Backpress: none; the chain cannot stall, DRAIN gaps separate trials instead.
//
// Ports:
//   clock0      sole clock, rising edge
//   rst1        asynchronous active-high reset
//   run         level, starts a session from IDLE; must drop in DONE before the next session
//   num_trials  trials per session, sampled on leaving IDLE
//   ff_in       final flop output of the chain under test
//   start       one-cycle launch pulse into the chain (high only in LAUNCH)
//   en_out      chain enable (LAUNCH, WAIT, DRAIN)
//   busy        session in progress (LAUNCH, WAIT, DRAIN)
//   done        session finished, results stable
//   pass        no errors; only meaningful while done=1
//   err_count   saturating error count
//   last_lat    latency captured on the most recent trial
//   lat_min/lat_max  extremes of captured latencies, present only with HOP_CHK_MINMAX_EN
//
// Build option: define HOP_CHK_MINMAX_EN to add the lat_min/lat_max tracking outputs.

module hop_chain_checker #(
    parameter int EXP_LAT = 9,
    parameter int TIMEOUT = 32,
    parameter int DRAIN   = 4,
    parameter int CNT_W   = 8,
    parameter int LAT_W   = 6
) (
    input  logic             clock0,
    input  logic             rst1,
    input  logic             run,
    input  logic [CNT_W-1:0] num_trials,
    input  logic             ff_in,
    output logic             start,
    output logic             en_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [LAT_W-1:0] last_lat
`ifdef HOP_CHK_MINMAX_EN
    ,
    output logic [LAT_W-1:0] lat_min,
    output logic [LAT_W-1:0] lat_max
`endif
);

    // Quiet counter only needs to count 0..DRAIN-1; the final low cycle exits.
    localparam int QW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    localparam logic [LAT_W-1:0] EXP_LAT_V = LAT_W'(EXP_LAT);
    localparam logic [LAT_W-1:0] TIMEOUT_V = LAT_W'(TIMEOUT);
    localparam logic [QW-1:0]    QUIET_LST = QW'(DRAIN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Session / trial bookkeeping
    logic [CNT_W-1:0] r_trials_left;
    logic [LAT_W-1:0] r_lat_cnt;
    logic [QW-1:0]    r_quiet;
    logic             r_drain_first;
    logic             r_hi_counted;

    // Registered outputs
    logic             r_start;
    logic             r_en;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_err;
    logic [LAT_W-1:0] r_last_lat;

    // Per-cycle event decode
    logic             w_session_start;
    logic             w_arrive;
    logic             w_timeout;
    logic             w_capture;
    logic [LAT_W-1:0] w_cap_lat;
    logic             w_lat_err;
    logic             w_drain_err;
    logic             w_drain_done;
    logic             w_err_inc;
    logic             w_nxt_active;

    assign w_session_start = (r_state == S_IDLE) && run;

    // An arrival on the timeout cycle wins, so that trial is a single
    // latency-mismatch error rather than mismatch plus timeout.
    assign w_arrive  = (r_state == S_WAIT) && ff_in;
    assign w_timeout = (r_state == S_WAIT) && !ff_in && (r_lat_cnt == TIMEOUT_V);
    assign w_capture = w_arrive || w_timeout;
    assign w_cap_lat = w_arrive ? r_lat_cnt : TIMEOUT_V;
    assign w_lat_err = w_timeout || (w_arrive && (r_lat_cnt != EXP_LAT_V));

    // The first DRAIN cycle may legitimately still see the tail of the
    // arriving pulse; after that any high is a stuck or duplicate pulse,
    // charged once per contiguous high run.
    assign w_drain_err  = (r_state == S_DRAIN) && ff_in && !r_drain_first && !r_hi_counted;
    assign w_drain_done = (r_state == S_DRAIN) && !ff_in && (r_quiet == QUIET_LST);
    assign w_err_inc    = w_lat_err || w_drain_err;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_state_nxt = (num_trials == '0) ? S_DONE : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_capture) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drain_done) begin
                    w_state_nxt = (r_trials_left == CNT_W'(1)) ? S_DONE : S_LAUNCH;
                end
            end
            S_DONE: begin
                // Requiring run to drop prevents a held run from looping sessions.
                if (!run) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_nxt_active = (w_state_nxt == S_LAUNCH) ||
                          (w_state_nxt == S_WAIT)   ||
                          (w_state_nxt == S_DRAIN);

    // ------------------------------------------------------------------
    // Outputs are registered from the next state so each one is high for
    // exactly the cycles its state is occupied, with no decode glitches.
    // ------------------------------------------------------------------
    always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1) begin
            r_start <= 1'b0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_start <= (w_state_nxt == S_LAUNCH);
            r_en    <= w_nxt_active;
            r_busy  <= w_nxt_active;
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    // ------------------------------------------------------------------
    // Trial datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1) begin
            r_trials_left <= '0;
            r_lat_cnt     <= '0;
            r_quiet       <= '0;
            r_drain_first <= 1'b0;
            r_hi_counted  <= 1'b0;
            r_err         <= '0;
            r_last_lat    <= '0;
        end else begin
            if (w_session_start) begin
                r_trials_left <= num_trials;
                r_err         <= '0;
                r_last_lat    <= '0;
            end

            // lat_cnt counts cycles since start was high: the first WAIT
            // cycle reads 1, so an N-flop chain arrives with lat_cnt == N.
            if (r_state == S_LAUNCH) begin
                r_lat_cnt <= LAT_W'(1);
            end else if ((r_state == S_WAIT) && !w_capture) begin
                r_lat_cnt <= r_lat_cnt + 1'b1;
            end

            if (w_capture) begin
                r_last_lat    <= w_cap_lat;
                r_quiet       <= '0;
                r_drain_first <= 1'b1;
                r_hi_counted  <= 1'b0;
            end

            if (r_state == S_DRAIN) begin
                r_drain_first <= 1'b0;
                if (ff_in) begin
                    r_quiet <= '0;
                end else if (!w_drain_done) begin
                    r_quiet <= r_quiet + 1'b1;
                end

                if (!ff_in) begin
                    r_hi_counted <= 1'b0;
                end else if (w_drain_err) begin
                    r_hi_counted <= 1'b1;
                end
            end

            if (w_drain_done) begin
                r_trials_left <= r_trials_left - 1'b1;
            end

            // Saturate rather than wrap so a badly broken chain never reads as clean.
            if (w_err_inc && (r_err != '1)) begin
                r_err <= r_err + 1'b1;
            end
        end
    end

`ifdef HOP_CHK_MINMAX_EN
    // ------------------------------------------------------------------
    // Latency extremes over the session, timeouts included.
    // ------------------------------------------------------------------
    logic [LAT_W-1:0] r_lat_min;
    logic [LAT_W-1:0] r_lat_max;

    always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1) begin
            r_lat_min <= '1;
            r_lat_max <= '0;
        end else if (w_session_start) begin
            r_lat_min <= '1;
            r_lat_max <= '0;
        end else if (w_capture) begin
            if (w_cap_lat < r_lat_min) begin
                r_lat_min <= w_cap_lat;
            end
            if (w_cap_lat > r_lat_max) begin
                r_lat_max <= w_cap_lat;
            end
        end
    end

    assign lat_min = r_lat_min;
    assign lat_max = r_lat_max;
`else
    // Min/max tracking not built; no extra state.
`endif

    assign start     = r_start;
    assign en_out    = r_en;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_done && (r_err == '0);
    assign err_count = r_err;
    assign last_lat  = r_last_lat;

endmodule

// File: tb/tb_hop_chain_checker.sv
`timescale 1ns/1ps
// Bench for hop_chain_checker: a behavioural chain model answers each start
// pulse, a negedge monitor scores per-trial latency, tasks check session results.

module tb_hop_chain_checker;

    localparam int CNT_W   = 8;
    localparam int LAT_W   = 6;
    localparam int EXP_LAT = 9;
    localparam int TIMEOUT = 32;
    localparam int DRAIN   = 4;

    // Chain model modes
    localparam int M_PULSE  = 0;  // single pulse after base_depth cycles
    localparam int M_LOW    = 1;  // ff_in tied 0
    localparam int M_HIGH   = 2;  // ff_in tied 1
    localparam int M_DOUBLE = 3;  // pulse at depth and a duplicate two cycles later
    localparam int M_ALT    = 4;  // depth alternates 9, 11, 9, 11, ...

    logic             clock0 = 1'b0;
    logic             rst1   = 1'b1;
    logic             run    = 1'b0;
    logic [CNT_W-1:0] num_trials = '0;
    logic             ff_in;
    logic             start;
    logic             en_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [LAT_W-1:0] last_lat;
`ifdef HOP_CHK_MINMAX_EN
    logic [LAT_W-1:0] lat_min;
    logic [LAT_W-1:0] lat_max;
`endif

    int vectors     = 0;
    int miscompares = 0;

    int mode       = M_PULSE;
    int base_depth = 9;
    int cur_depth  = 0;
    int age        = 0;
    int n_launch   = 0;
    int cyc_now    = 0;
    int start_cyc_q[$];
    int exp_q[$];

    hop_chain_checker #(
        .EXP_LAT (EXP_LAT),
        .TIMEOUT (TIMEOUT),
        .DRAIN   (DRAIN),
        .CNT_W   (CNT_W),
        .LAT_W   (LAT_W)
    ) dut (
        .clock0     (clock0),
        .rst1       (rst1),
        .run        (run),
        .num_trials (num_trials),
        .ff_in      (ff_in),
        .start      (start),
        .en_out     (en_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .last_lat   (last_lat)
`ifdef HOP_CHK_MINMAX_EN
        ,
        .lat_min    (lat_min),
        .lat_max    (lat_max)
`endif
    );

    always #5 clock0 = ~clock0;

    always @(posedge clock0) cyc_now <= cyc_now + 1;

    function automatic int depth_of(input int idx);
        if (mode == M_ALT) return ((idx % 2) == 0) ? 9 : 11;
        return base_depth;
    endfunction

    // Chain model: age is the number of cycles since start was high.
    always @(posedge clock0 or posedge rst1) begin
        if (rst1)                        age <= 0;
        else if (start)                  age <= 1;
        else if (age != 0 && age < 1000) age <= age + 1;
    end

    always_comb begin
        case (mode)
            M_LOW:    ff_in = 1'b0;
            M_HIGH:   ff_in = 1'b1;
            M_DOUBLE: ff_in = (age == cur_depth) || (age == cur_depth + 2);
            default:  ff_in = (age == cur_depth);
        endcase
    end

    // Scoreboard: expected capture pushed at each launch, checked the cycle
    // after the capture is due.
    always @(negedge clock0) begin
        if (rst1) begin
            exp_q.delete();
        end else if (start) begin
            start_cyc_q.push_back(cyc_now);
            cur_depth = depth_of(n_launch);
            n_launch++;
            if (mode == M_LOW)       exp_q.push_back(TIMEOUT);
            else if (mode == M_HIGH) exp_q.push_back(1);
            else if (cur_depth > TIMEOUT) exp_q.push_back(TIMEOUT);
            else                     exp_q.push_back(cur_depth);
        end else if (exp_q.size() != 0 && age == exp_q[0] + 1) begin
            vectors++;
            if (last_lat !== LAT_W'(exp_q[0])) begin
                miscompares++;
                $display("FAIL trial_lat: launch %0d last_lat=%0d expected %0d", n_launch, last_lat, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock0);
            #1;
        end
    endtask

    task automatic new_session(input int m, input int depth, input int trials);
        mode = m;
        base_depth = depth;
        n_launch = 0;
        start_cyc_q.delete();
        num_trials = CNT_W'(trials);
        run = 1'b1;
    endtask

    task automatic wait_done(input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            tick(1);
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst1 = 1'b1;
        tick(2);
        vectors++; if (start !== 1'b0)  begin miscompares++; $display("FAIL rst_start: got %b want 0", start); end
        vectors++; if (en_out !== 1'b0) begin miscompares++; $display("FAIL rst_en: got %b want 0", en_out); end
        vectors++; if (busy !== 1'b0)   begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0)   begin miscompares++; $display("FAIL rst_done: got %b want 0", done); end
        vectors++; if (pass !== 1'b0)   begin miscompares++; $display("FAIL rst_pass: got %b want 0", pass); end
        vectors++; if (err_count !== '0) begin miscompares++; $display("FAIL rst_err: got %0d want 0", err_count); end
        vectors++; if (last_lat !== '0)  begin miscompares++; $display("FAIL rst_lat: got %0d want 0", last_lat); end
`ifdef HOP_CHK_MINMAX_EN
        vectors++; if (lat_min !== 6'h3f) begin miscompares++; $display("FAIL rst_min: got %0d want 63", lat_min); end
        vectors++; if (lat_max !== 6'h00) begin miscompares++; $display("FAIL rst_max: got %0d want 0", lat_max); end
`endif
        rst1 = 1'b0;
        tick(1);
    endtask

    task automatic test_ideal;
        int n;
        new_session(M_PULSE, 9, 5);
        tick(1);
        vectors++; if (start !== 1'b1) begin miscompares++; $display("FAIL ideal_first_start: got %b want 1", start); end
        vectors++; if (busy !== 1'b1 || en_out !== 1'b1) begin miscompares++; $display("FAIL ideal_busy_en: got %b%b want 11", busy, en_out); end
        wait_done(200, n);
        vectors++; if (n < 0) begin miscompares++; $display("FAIL ideal_done: not seen in 200 cycles"); end
        vectors++; if (pass !== 1'b1) begin miscompares++; $display("FAIL ideal_pass: got %b want 1", pass); end
        vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL ideal_err: got %0d want 0", err_count); end
        vectors++; if (last_lat !== 6'd9) begin miscompares++; $display("FAIL ideal_lat: got %0d want 9", last_lat); end
        vectors++; if (busy !== 1'b0 || en_out !== 1'b0) begin miscompares++; $display("FAIL ideal_idle_out: got %b%b want 00", busy, en_out); end
        vectors++; if (start_cyc_q.size() != 5) begin miscompares++; $display("FAIL ideal_starts: got %0d want 5", start_cyc_q.size()); end
        for (int i = 1; i < start_cyc_q.size(); i++) begin
            vectors++;
            if (start_cyc_q[i] - start_cyc_q[i-1] != 14) begin
                miscompares++;
                $display("FAIL ideal_spacing: gap %0d got %0d want 14", i, start_cyc_q[i] - start_cyc_q[i-1]);
            end
        end
        tick(5);
        vectors++; if (done !== 1'b1 || n_launch != 5) begin miscompares++; $display("FAIL ideal_hold: done=%b launches=%0d want 1/5", done, n_launch); end
        run = 1'b0;
        tick(1);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL ideal_release: done=%b want 0", done); end
    endtask

    task automatic test_late;
        int n;
        new_session(M_PULSE, 10, 3);
        wait_done(200, n);
        vectors++; if (n < 0) begin miscompares++; $display("FAIL late_done: not seen"); end
        vectors++; if (err_count !== 8'd3) begin miscompares++; $display("FAIL late_err: got %0d want 3", err_count); end
        vectors++; if (pass !== 1'b0) begin miscompares++; $display("FAIL late_pass: got %b want 0", pass); end
        vectors++; if (start_cyc_q.size() == 3 && start_cyc_q[1] - start_cyc_q[0] != 15) begin miscompares++; $display("FAIL late_spacing: got %0d want 15", start_cyc_q[1] - start_cyc_q[0]); end
        run = 1'b0;
        tick(1);
    endtask

    task automatic test_zero_trials;
        new_session(M_PULSE, 9, 0);
        tick(1);
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL zero_done: got %b want 1", done); end
        vectors++; if (pass !== 1'b1) begin miscompares++; $display("FAIL zero_pass: got %b want 1", pass); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL zero_busy: got %b want 0", busy); end
        tick(3);
        vectors++; if (n_launch != 0) begin miscompares++; $display("FAIL zero_start: got %0d launches want 0", n_launch); end
        run = 1'b0;
        tick(1);
    endtask

    task automatic test_timeout;
        int n;
        new_session(M_LOW, 0, 2);
        wait_done(200, n);
        vectors++; if (n < 0) begin miscompares++; $display("FAIL tmo_done: not seen"); end
        vectors++; if (err_count !== 8'd2) begin miscompares++; $display("FAIL tmo_err: got %0d want 2", err_count); end
        vectors++; if (last_lat !== 6'd32) begin miscompares++; $display("FAIL tmo_lat: got %0d want 32", last_lat); end
        vectors++; if (start_cyc_q.size() == 2 && start_cyc_q[1] - start_cyc_q[0] != 37) begin miscompares++; $display("FAIL tmo_spacing: got %0d want 37", start_cyc_q[1] - start_cyc_q[0]); end
        run = 1'b0;
        tick(1);
    endtask

    task automatic test_timeout_edge;
        int n;
        new_session(M_PULSE, 32, 1);
        wait_done(100, n);
        vectors++; if (n < 0) begin miscompares++; $display("FAIL tedge_done: not seen"); end
        vectors++; if (err_count !== 8'd1) begin miscompares++; $display("FAIL tedge_err: got %0d want 1", err_count); end
        vectors++; if (last_lat !== 6'd32) begin miscompares++; $display("FAIL tedge_lat: got %0d want 32", last_lat); end
        run = 1'b0;
        tick(1);
    endtask

    task automatic test_alternating;
        int n;
        new_session(M_ALT, 0, 4);
        wait_done(200, n);
        vectors++; if (n < 0) begin miscompares++; $display("FAIL alt_done: not seen"); end
        vectors++; if (err_count !== 8'd2) begin miscompares++; $display("FAIL alt_err: got %0d want 2", err_count); end
        vectors++; if (last_lat !== 6'd11) begin miscompares++; $display("FAIL alt_lat: got %0d want 11", last_lat); end
`ifdef HOP_CHK_MINMAX_EN
        vectors++; if (lat_min !== 6'd9)  begin miscompares++; $display("FAIL alt_min: got %0d want 9", lat_min); end
        vectors++; if (lat_max !== 6'd11) begin miscompares++; $display("FAIL alt_max: got %0d want 11", lat_max); end
`endif
        run = 1'b0;
        tick(1);
    endtask

    task automatic test_saturate;
        int n;
        new_session(M_DOUBLE, 10, 140);
        wait_done(5000, n);
        vectors++; if (n < 0) begin miscompares++; $display("FAIL sat_done: not seen"); end
        vectors++; if (n_launch != 140) begin miscompares++; $display("FAIL sat_launches: got %0d want 140", n_launch); end
        vectors++; if (err_count !== 8'd255) begin miscompares++; $display("FAIL sat_err: got %0d want 255", err_count); end
        vectors++; if (pass !== 1'b0) begin miscompares++; $display("FAIL sat_pass: got %b want 0", pass); end
        run = 1'b0;
        tick(1);
    endtask

    task automatic test_stuck_high;
        new_session(M_HIGH, 0, 3);
        tick(60);
        vectors++; if (busy !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL stuck_busy: busy=%b done=%b want 1/0", busy, done); end
        vectors++; if (err_count !== 8'd2) begin miscompares++; $display("FAIL stuck_err: got %0d want 2", err_count); end
        vectors++; if (n_launch != 1) begin miscompares++; $display("FAIL stuck_launch: got %0d want 1", n_launch); end
        run  = 1'b0;
        rst1 = 1'b1;
        #1;
        vectors++; if (busy !== 1'b0 || en_out !== 1'b0) begin miscompares++; $display("FAIL stuck_async_rst: busy=%b en=%b want 0/0", busy, en_out); end
        tick(1);
        rst1 = 1'b0;
        mode = M_PULSE;
        tick(1);
    endtask

    task automatic test_reset_mid_wait;
        int n;
        new_session(M_PULSE, 10, 3);
        for (int i = 0; i < 100 && n_launch < 2; i++) tick(1);
        tick(3);
        vectors++; if (err_count !== 8'd1) begin miscompares++; $display("FAIL midrst_pre_err: got %0d want 1", err_count); end
        rst1 = 1'b1;
        run  = 1'b0;
        tick(1);
        vectors++; if (start !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL midrst_out: start=%b busy=%b want 0/0", start, busy); end
        vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL midrst_err: got %0d want 0", err_count); end
        vectors++; if (done !== 1'b0 || en_out !== 1'b0) begin miscompares++; $display("FAIL midrst_done_en: done=%b en=%b want 0/0", done, en_out); end
        rst1 = 1'b0;
        tick(1);
        new_session(M_PULSE, 10, 3);
        tick(1);
        vectors++; if (start !== 1'b1) begin miscompares++; $display("FAIL midrst_idle: start=%b want 1", start); end
        wait_done(200, n);
        vectors++; if (n < 0 || err_count !== 8'd3) begin miscompares++; $display("FAIL midrst_rerun: done_after=%0d err=%0d want err 3", n, err_count); end
        run = 1'b0;
        tick(1);
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_late();
        test_zero_trials();
        test_timeout();
        test_timeout_edge();
        test_alternating();
        test_saturate();
        test_stuck_high();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
